// File: rtl/mips_data_ram.sv
// Word-addressed MIPS data RAM: combinational reads, single-cycle writes, sticky fault capture.
// Define MIPS_DATA_RAM_CLEAR_EN to zero-fill the array after every reset before raising ready.
module mips_data_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        ready,
  output logic        fault,
  output logic [31:0] fault_address
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   offset;
  logic [AW-1:0] wordIdx;
  logic          inRange;
  logic          legal;
  logic          faultSet;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic          fault_q, fault_d;
  logic [31:0]   faultAddr_q, faultAddr_d;

  // The span check uses 33 bits so a window ending at the top of the address space still decodes.
  assign offset   = data_address - BASE_ADDR;
  assign wordIdx  = offset[AW+1:2];
  assign inRange  = (data_address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign legal    = ready && (data_address[1:0] == 2'b00) && inRange && !(data_read && data_write);
  assign faultSet = ready && (data_read || data_write) && !legal;

  assign data_readdata = (legal && data_read) ? mem_q[wordIdx] : 32'h0;

`ifdef MIPS_DATA_RAM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clearWe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The index parks on its last value once READY is reached, so it never re-enters CLEAR.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = READY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READY: ;
    endcase
  end

  always_comb begin
    ready   = (state_q == READY);
    clearWe = (state_q == CLEAR);
  end
`else
  logic ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign ready = ready_q;
`endif

  always_comb begin
    memWe   = legal && data_write;
    memAddr = wordIdx;
    memData = data_writedata;
`ifdef MIPS_DATA_RAM_CLEAR_EN
    if (clearWe) begin
      memWe   = 1'b1;
      memAddr = idx_q;
      memData = 32'h0;
    end
`endif
  end

  // The array has no reset so its contents survive reset when the clear sweep is compiled out.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  always_comb begin
    fault_d     = fault_q || faultSet;
    faultAddr_d = (faultSet && !fault_q) ? data_address : faultAddr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q     <= 1'b0;
      faultAddr_q <= 32'h0;
    end else begin
      fault_q     <= fault_d;
      faultAddr_q <= faultAddr_d;
    end
  end

  assign fault         = fault_q;
  assign fault_address = faultAddr_q;

endmodule

// File: doc/mips_data_ram.md
MIPS_DATA_RAM -- requirements
Module: mips_data_ram

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words (power of two, 4..65536).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, giving the byte address of word 0 (aligned to DEPTH_WORDS*4).

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port data_address, input, 32, the byte address from the CPU.
REQ-006 The block SHALL have port data_write, input, 1, the write request.
REQ-007 The block SHALL have port data_read, input, 1, the read request.
REQ-008 The block SHALL have port data_writedata, input, 32, the write data.
REQ-009 The block SHALL have port data_readdata, output, 32, the combinational read data.
REQ-010 The block SHALL have port ready, output, 1, which is high when the memory accepts accesses.
REQ-011 The block SHALL have port fault, output, 1, a sticky illegal-access flag.
REQ-012 The block SHALL have port fault_address, output, 32, the address of the first faulting access.

Function
REQ-013 The block SHALL decode an access as legal when ready=1, data_address[1:0]=0, BASE_ADDR <= data_address < BASE_ADDR+4*DEPTH_WORDS, and data_read and data_write are not both high.
REQ-014 Reads SHALL be combinational: a legal data_read=1 drives data_readdata with word (data_address-BASE_ADDR)>>2 in the same cycle, with no clock edge needed.
REQ-015 data_readdata SHALL be 32'h0 whenever data_read=0, the access is illegal, or ready=0.
REQ-016 Writes SHALL be single-cycle: a legal data_write=1 stores data_writedata at the rising edge, and the new value is readable from the following cycle.
REQ-017 A read of the same address in the write cycle SHALL return the old value (no write-to-read bypass).
REQ-018 Illegal writes SHALL NOT modify memory.
REQ-019 Any request (data_read or data_write high) that fails REQ-013 while ready=1 SHALL set fault at the next edge.
REQ-020 fault_address SHALL capture data_address only on the 0->1 transition of fault, so later faults do not overwrite it.
REQ-021 Requests while ready=0 SHALL be ignored and SHALL NOT set fault.
REQ-022 Once set, fault SHALL be cleared only by reset.
REQ-023 The state machine SHALL have states CLEAR and READY.
- CLEAR: an internal index counts 0..DEPTH_WORDS-1 and writes 32'h0 to one word per cycle; ready=0.
- CLEAR -> READY: on the edge after the write of index DEPTH_WORDS-1.
- READY: ready=1; stays in READY until reset.
REQ-024 The index counter SHALL be log2(DEPTH_WORDS) bits wide and SHALL NOT wrap back into CLEAR.

Reset
REQ-025 Asserting reset low SHALL immediately force ready=0, fault=0, fault_address=32'h0 and the clear index to 0, independent of clk.
REQ-026 During reset data_readdata SHALL be 32'h0.
REQ-027 Reset asserted mid-CLEAR or mid-write SHALL abort the operation; the sequence restarts from index 0 after release.
REQ-028 After reset deasserts, the first state SHALL be CLEAR (macro defined) or READY (macro undefined).

Configuration
REQ-029 Macro MIPS_DATA_RAM_CLEAR_EN, when defined, SHALL compile in the CLEAR state, giving a zero-filled array, with ready rising DEPTH_WORDS cycles after reset release.
REQ-030 When MIPS_DATA_RAM_CLEAR_EN is undefined, the block SHALL omit the CLEAR state and index counter, raise ready on the first rising edge after reset release, and leave array contents unchanged across reset (X at power-up in simulation).

Verification
REQ-031 The bench SHALL cover: CLEAR_EN defined, DEPTH_WORDS=16, release reset -> ready low for exactly 16 cycles, then high; every word reads 32'h0.
REQ-032 The bench SHALL cover: write 32'hDEADBEEF to 32'h0000_1008, then read it the next cycle -> data_readdata=32'hDEADBEEF in the same cycle; a same-cycle read during the write -> old value.
REQ-033 The bench SHALL cover: read 32'h0000_1002 -> data_readdata=0; fault=1 next cycle; fault_address=32'h0000_1002.
REQ-034 The bench SHALL cover: after REQ-033, write to 32'h0000_0FFC -> no memory change; fault stays 1; fault_address stays 32'h0000_1002.
REQ-035 The bench SHALL cover: data_read=data_write=1 at a valid address -> no write; fault=1.
REQ-036 The bench SHALL cover: reset pulsed low at CLEAR index 7 -> ready=0 and fault=0 at once; after release, ready rises 16 cycles later.
